axi_lite_master_block: RTL and testbench

AXI_LITE_MASTER_BLOCK -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_master_block.sv | 124 ++++++++++++
 tb/tb_axi_lite_master_block.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_master_block.sv
// Single-outstanding AXI-Lite master: one user request becomes one AXI read or write.
// Every output is a flop or a constant, so no input reaches an output combinationally.
module axi_lite_master_block #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    // user side
    input  logic                  rw_enable,
    input  logic                  rw_transaction,
    input  logic [ADDR_W-1:0]     address,
    input  logic [DATA_W-1:0]     write_data,
    output logic [DATA_W-1:0]     read_data,
    // read channels
    output logic [ADDR_W-1:0]     araddr,
    output logic [3:0]            arcache,
    output logic [2:0]            arprot,
    output logic                  arvalid,
    input  logic                  arready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    input  logic                  rvalid,
    output logic                  rready,
    // write channels
    output logic [ADDR_W-1:0]     awaddr,
    output logic [3:0]            awcache,
    output logic [2:0]            awprot,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    output logic                  wvalid,
    input  logic                  wready,
    input  logic [1:0]            bresp,
    input  logic                  bvalid,
    output logic                  bready
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ADDR,
        RD_DATA,
        WR_REQ,
        WR_RESP
    } state_t;

    state_t state;

    assign arcache = 4'b0000;
    assign awcache = 4'b0000;
    assign arprot  = 3'b000;
    assign awprot  = 3'b000;
    assign wstrb   = '1;

    // Response codes are deliberately ignored; this keeps them visibly consumed.
    logic unused_resp;
    assign unused_resp = ^{rresp, bresp};

    // aresetn is active-high despite its name.
    always_ff @(posedge aclk or posedge aresetn) begin
        if (aresetn) begin
            state     <= IDLE;
            arvalid   <= 1'b0;
            rready    <= 1'b0;
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            bready    <= 1'b0;
            araddr    <= '0;
            awaddr    <= '0;
            wdata     <= '0;
            read_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rw_enable) begin
                        if (rw_transaction) begin
                            araddr  <= address;
                            arvalid <= 1'b1;
                            state   <= RD_ADDR;
                        end else begin
                            awaddr  <= address;
                            wdata   <= write_data;
                            awvalid <= 1'b1;
                            wvalid  <= 1'b1;
                            state   <= WR_REQ;
                        end
                    end
                end
                RD_ADDR: begin
                    if (arready) begin
                        arvalid <= 1'b0;
                        rready  <= 1'b1;
                        state   <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (rvalid) begin
                        read_data <= rdata;
                        rready    <= 1'b0;
                        state     <= IDLE;
                    end
                end
                WR_REQ: begin
                    if (awvalid && awready) awvalid <= 1'b0;
                    if (wvalid && wready)   wvalid  <= 1'b0;
                    // A low valid here means that channel already handshook.
                    if ((!awvalid || awready) && (!wvalid || wready)) begin
                        bready <= 1'b1;
                        state  <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (bvalid) begin
                        bready <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_master_block.sv
// Bench for axi_lite_master_block: a table of transactions against a delay-programmable
// slave with a register model, plus reset, random and ignored-request sequences.
module tb_axi_lite_master_block;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b1;
    logic        rw_enable = 1'b0;
    logic        rw_transaction = 1'b0;
    logic [4:0]  address = '0;
    logic [31:0] write_data = '0;
    logic [31:0] read_data;
    logic [4:0]  araddr;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [4:0]  awaddr;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = 2'b00;
    logic        bvalid = 1'b0;
    logic        bready;

    axi_lite_master_block #(.ADDR_W(5), .DATA_W(32)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .rw_enable(rw_enable), .rw_transaction(rw_transaction),
        .address(address), .write_data(write_data), .read_data(read_data),
        .araddr(araddr), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
        .arready(arready), .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
        .awready(awready), .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready)
    );

    always #5 aclk = ~aclk;

    int          tests = 0;
    int          fails = 0;
    logic [31:0] mem [32];    // slave storage, filled from what the DUT actually sent
    logic [31:0] model [32];  // what the bench intended to write
    logic [31:0] sb_q [$];

    typedef struct {
        bit          rd;
        logic [4:0]  addr;
        logic [31:0] data;
        int          d0;   // write: aw delay  / read: ar delay
        int          d1;   // write: w delay   / read: r delay
        int          d2;   // write: b delay
        logic [31:0] exp;  // expected read_data for reads
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic issue(input bit rd, input logic [4:0] a, input logic [31:0] d);
        rw_enable = 1'b1;
        rw_transaction = rd;
        address = a;
        write_data = d;
        cyc();
        rw_enable = 1'b0;
        address = 5'($urandom);
        write_data = $urandom;
    endtask

    task automatic do_write(input logic [4:0] a, input logic [31:0] d,
                            input int awd, input int wd, input int bd);
        int mx = (awd > wd) ? awd : wd;
        bit done = 1'b0;
        logic [4:0] ca = '0;
        logic [31:0] cd = '0;
        issue(1'b0, a, d);
        chk("wr_first", 64'({awvalid, wvalid, awaddr, wdata, wstrb}), 64'({2'b11, a, d, 4'hF}));
        for (int n = 0; n < 60 && !done; n++) begin
            chk("wr_ctl", 64'({arvalid, rready, awvalid, wvalid, bready}),
                64'({2'b00, n <= awd, n <= wd, (n > mx) && (n <= mx + 1 + bd)}));
            if (n == mx + bd + 2) begin
                done = 1'b1;
            end else begin
                if (awvalid) chk("wr_awaddr", 64'(awaddr), 64'(a));
                if (wvalid)  chk("wr_wdata", 64'(wdata), 64'(d));
                awready = (n == awd);
                wready  = (n == wd);
                bvalid  = (n == mx + 1 + bd);
                if (awvalid && awready) ca = awaddr;
                if (wvalid && wready)   cd = wdata;
                cyc();
            end
        end
        awready = 1'b0;
        wready  = 1'b0;
        bvalid  = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL wr_timeout: got no completion expected completion by %0d cycles", mx + bd + 2);
        end
        mem[ca] = cd;
        model[a] = d;
        $display("[TB] write addr=%h data=%h awd=%0d wd=%0d bd=%0d", a, d, awd, wd, bd);
    endtask

    task automatic do_read(input logic [4:0] a, input int ard, input int rd,
                           input bit pulse, input logic [31:0] exp);
        bit done = 1'b0;
        logic [4:0] ca = '0;
        logic [31:0] prev = read_data;
        logic [31:0] got;
        sb_q.push_back(exp);
        issue(1'b1, a, 32'h0);
        chk("rd_first", 64'({arvalid, araddr}), 64'({1'b1, a}));
        for (int n = 0; n < 60 && !done; n++) begin
            chk("rd_ctl", 64'({arvalid, rready, awvalid, wvalid, bready}),
                64'({n <= ard, (n > ard) && (n <= ard + 1 + rd), 3'b000}));
            if (n == ard + rd + 2) begin
                done = 1'b1;
            end else begin
                chk("rd_hold", 64'(read_data), 64'(prev));
                if (arvalid) chk("rd_araddr", 64'(araddr), 64'(a));
                arready = (n == ard);
                rvalid  = (n == ard + 1 + rd);
                if (arvalid && arready) ca = araddr;
                rdata = rvalid ? mem[ca] : $urandom;
                rw_enable = pulse && (n == ard + 1);
                rw_transaction = 1'b0;
                address = ~a;
                cyc();
            end
        end
        rw_enable = 1'b0;
        arready = 1'b0;
        rvalid  = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL rd_timeout: got no completion expected completion by %0d cycles", ard + rd + 2);
        end
        got = sb_q.pop_front();
        chk("rd_data", 64'(read_data), 64'(got));
        if (pulse) begin
            cyc();
            chk("rd_pulse_idle", 64'({arvalid, rready, awvalid, wvalid, bready, read_data}),
                64'({5'b00000, got}));
        end
        $display("[TB] read  addr=%h data=%h ard=%0d rd=%0d pulse=%0d", a, read_data, ard, rd, pulse);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000 ns");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b0, 5'h0A, 32'hDEADBEEF, 0, 0, 0, 32'h0};
        vecs[1]  = '{1'b1, 5'h0A, 32'h0,        0, 0, 0, 32'hDEADBEEF};
        vecs[2]  = '{1'b0, 5'h0A, 32'hDEADBEEF, 3, 0, 0, 32'h0};
        vecs[3]  = '{1'b1, 5'h0A, 32'h0,        2, 4, 0, 32'hDEADBEEF};
        vecs[4]  = '{1'b0, 5'h03, 32'h12345678, 0, 2, 1, 32'h0};
        vecs[5]  = '{1'b0, 5'h1F, 32'hA5A5A5A5, 2, 2, 2, 32'h0};
        vecs[6]  = '{1'b1, 5'h03, 32'h0,        1, 0, 0, 32'h12345678};
        vecs[7]  = '{1'b1, 5'h1F, 32'h0,        0, 3, 0, 32'hA5A5A5A5};
        vecs[8]  = '{1'b0, 5'h00, 32'h00000001, 1, 4, 0, 32'h0};
        vecs[9]  = '{1'b1, 5'h00, 32'h0,        0, 1, 0, 32'h00000001};
        vecs[10] = '{1'b1, 5'h0A, 32'h0,        0, 0, 0, 32'hDEADBEEF};
        for (int i = 0; i < 32; i++) begin
            mem[i] = '0;
            model[i] = '0;
        end

        // reset state
        cyc();
        cyc();
        chk("rst_ctl", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'(5'b00000));
        chk("rst_regs", 64'({araddr, awaddr, wdata}), 64'(0));
        chk("rst_rdata", 64'(read_data), 64'(0));
        chk("consts", 64'({arcache, awcache, arprot, awprot, wstrb}),
            64'({4'h0, 4'h0, 3'h0, 3'h0, 4'hF}));
        aresetn = 1'b0;
        cyc();

        for (int i = 0; i < 11; i++) begin
            if (vecs[i].rd)
                do_read(vecs[i].addr, vecs[i].d0, vecs[i].d1, 1'b0, vecs[i].exp);
            else
                do_write(vecs[i].addr, vecs[i].data, vecs[i].d0, vecs[i].d1, vecs[i].d2);
        end

        for (int i = 0; i < 10; i++) begin
            logic [4:0]  a = 5'($urandom_range(0, 31));
            logic [31:0] d = $urandom;
            do_write(a, d, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            do_read(a, $urandom_range(0, 3), $urandom_range(0, 3), 1'b0, model[a]);
        end

        // request pulsed while waiting for read data must be dropped
        do_read(5'h0A, 1, 3, 1'b1, model[5'h0A]);

        // reset in the middle of a write with awvalid high
        issue(1'b0, 5'h11, 32'hCAFEF00D);
        cyc();
        chk("mid_wr_busy", 64'({awvalid, awaddr}), 64'({1'b1, 5'h11}));
        #2 aresetn = 1'b1;
        #1;
        chk("async_rst_ctl", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'(5'b00000));
        chk("async_rst_regs", 64'({araddr, awaddr, wdata}), 64'(0));
        chk("async_rst_rdata", 64'(read_data), 64'(0));
        @(negedge aclk);
        aresetn = 1'b0;
        cyc();
        chk("post_rst_idle", 64'({arvalid, rready, awvalid, wvalid, bready}), 64'(5'b00000));
        do_write(5'h11, 32'h0BADCAFE, 0, 1, 0);
        do_read(5'h11, 0, 0, 1'b0, model[5'h11]);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
